clk_rst_seq: RTL and testbench

Power-up and recovery sequencer for the clock-generation MMCM feeding the 100 MHz core and ADS sample domains. Drives the MMCM reset, qualifies its LOCKED output, and releases the core and ADS resets in stages. Loss of lock or a lock timeout triggers an automatic retry, up to a retry limit. The block sits between the board reset pin and every downstream reset consumer, and all downstream logic treats `ready` as the single "clocks valid" indication.

---
 rtl/clk_rst_seq.sv | 179 +++++++++++++++++
 tb/tb_clk_rst_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// MMCM power-up / recovery sequencer: drives mmcm_rst, qualifies LOCKED, releases core then ADS resets.
// Optional lock-loss event counter on loss_cnt is enabled by defining CLK_RST_SEQ_LOSS_LOG_EN.
module clk_rst_seq #(
   parameter int unsigned MMCM_RST_CYC     = 16,
   parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned RST_STAGE_GAP    = 64,
   parameter int unsigned MAX_RETRY        = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       locked,
   input  logic       soft_rst,
   output logic       mmcm_rst,
   output logic       clk_en,
   output logic       rst_core,
   output logic       rst_ads,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   // One phase counter is shared by all timed states, so it is sized for the largest limit.
   localparam int unsigned MAX_AB  = (MMCM_RST_CYC > LOCK_TIMEOUT_CYC) ? MMCM_RST_CYC : LOCK_TIMEOUT_CYC;
   localparam int unsigned MAX_CD  = (LOCK_STABLE_CYC > RST_STAGE_GAP) ? LOCK_STABLE_CYC : RST_STAGE_GAP;
   localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] MRST_LAST    = CW'(MMCM_RST_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] STABLE_DONE  = CW'(LOCK_STABLE_CYC);
   localparam logic [CW-1:0] GAP_LAST     = CW'(RST_STAGE_GAP - 1);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_MRST, S_WAIT_LOCK, S_STABLE, S_REL_CORE, S_REL_ADS, S_RUN, S_FAULT
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]    retry_nx, retry_inc;
   logic          fail;
   logic          sync_q, locked_s;
   logic          mmcm_rst_nx, clk_en_nx, rst_core_nx, rst_ads_nx, ready_nx, fault_nx;

   // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q   <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_q   <= locked;
         locked_s <= sync_q;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt + 1'b1;
      retry_nx  = retry_cnt;
      fail      = 1'b0;
      retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

      case (state)
         S_MRST: begin
            if (cnt == MRST_LAST) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_nx = S_STABLE;
               cnt_nx   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               fail = 1'b1;
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == STABLE_DONE) begin
               state_nx = S_REL_CORE;
               cnt_nx   = '0;
            end
         end
         S_REL_CORE: begin
            if (!locked_s) begin
               fail = 1'b1;
            end else if (cnt == GAP_LAST) begin
               state_nx = S_REL_ADS;
               cnt_nx   = '0;
            end
         end
         S_REL_ADS: begin
            if (!locked_s) begin
               fail = 1'b1;
            end else if (cnt == GAP_LAST) begin
               state_nx = S_RUN;
               cnt_nx   = '0;
               retry_nx = '0;
            end
         end
         S_RUN: begin
            cnt_nx = '0;
            if (!locked_s) fail = 1'b1;
         end
         S_FAULT: cnt_nx = '0;
         default: begin
            state_nx = S_MRST;
            cnt_nx   = '0;
         end
      endcase

      if (fail) begin
         cnt_nx   = '0;
         retry_nx = retry_inc;
         state_nx = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_MRST;
      end

      // A restart request overrides whatever the current state decided, including a failure.
      if (soft_rst) begin
         state_nx = S_MRST;
         cnt_nx   = '0;
         retry_nx = '0;
      end

      mmcm_rst_nx = (state_nx == S_MRST) || (state_nx == S_FAULT);
      clk_en_nx   = state_nx inside {S_REL_CORE, S_REL_ADS, S_RUN};
      rst_core_nx = !(state_nx inside {S_REL_ADS, S_RUN});
      rst_ads_nx  = (state_nx != S_RUN);
      ready_nx    = (state_nx == S_RUN);
      fault_nx    = (state_nx == S_FAULT);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= S_MRST;
         cnt       <= '0;
         retry_cnt <= '0;
         mmcm_rst  <= 1'b1;
         clk_en    <= 1'b0;
         rst_core  <= 1'b1;
         rst_ads   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         retry_cnt <= retry_nx;
         mmcm_rst  <= mmcm_rst_nx;
         clk_en    <= clk_en_nx;
         rst_core  <= rst_core_nx;
         rst_ads   <= rst_ads_nx;
         ready     <= ready_nx;
         fault     <= fault_nx;
      end
   end

`ifdef CLK_RST_SEQ_LOSS_LOG_EN
   // Only lock loss after release counts; timeouts and STABLE glitches are not logged.
   logic lock_loss;
   assign lock_loss = !soft_rst && !locked_s && (state inside {S_REL_CORE, S_REL_ADS, S_RUN});

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         loss_cnt <= '0;
      end else if (lock_loss && (loss_cnt != 8'hFF)) begin
         loss_cnt <= loss_cnt + 8'd1;
      end
   end
`else
   assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: phase/age reference model compared every cycle,
// directed bring-up, glitch, timeout, loss, soft restart and async reset scenarios plus random lock traffic.
module tb_clk_rst_seq;

   localparam int MMCM_RST_CYC     = 4;
   localparam int LOCK_TIMEOUT_CYC = 50;
   localparam int LOCK_STABLE_CYC  = 8;
   localparam int RST_STAGE_GAP    = 4;
   localparam int MAX_RETRY        = 2;

`ifdef CLK_RST_SEQ_LOSS_LOG_EN
   localparam bit LOSS_LOG = 1'b1;
`else
   localparam bit LOSS_LOG = 1'b0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       locked;
   logic       soft_rst;
   logic       mmcm_rst, clk_en, rst_core, rst_ads, ready, fault;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef enum int {P_MRST, P_WAIT, P_STABLE, P_CORE, P_ADS, P_RUN, P_FAULT} phase_t;

   phase_t m_phase;
   int     m_age;
   int     m_retry;
   int     m_loss;
   bit     m_s1, m_s2;

   clk_rst_seq #(
      .MMCM_RST_CYC     (MMCM_RST_CYC),
      .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
      .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
      .RST_STAGE_GAP    (RST_STAGE_GAP),
      .MAX_RETRY        (MAX_RETRY)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .locked    (locked),
      .soft_rst  (soft_rst),
      .mmcm_rst  (mmcm_rst),
      .clk_en    (clk_en),
      .rst_core  (rst_core),
      .rst_ads   (rst_ads),
      .ready     (ready),
      .fault     (fault),
      .retry_cnt (retry_cnt),
      .loss_cnt  (loss_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_MRST;
      m_age   = 0;
      m_retry = 0;
      m_loss  = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
   endtask

   task automatic enter(input phase_t p);
      m_phase = p;
      m_age   = 0;
   endtask

   // m_age = clock edges spent in the current phase, including the edge now being evaluated.
   task automatic model_step();
      bit ls, failed, lost;
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      ls     = m_s2;
      m_s2   = m_s1;
      m_s1   = locked;
      failed = 1'b0;
      lost   = 1'b0;
      m_age++;
      if (soft_rst) begin
         enter(P_MRST);
         m_retry = 0;
      end else begin
         case (m_phase)
            P_MRST:   if (m_age == MMCM_RST_CYC) enter(P_WAIT);
            P_WAIT: begin
               if (ls) enter(P_STABLE);
               else if (m_age == LOCK_TIMEOUT_CYC) failed = 1'b1;
            end
            // The entry edge already saw lock; a full count of further locked cycles is then acted on.
            P_STABLE: begin
               if (!ls) enter(P_WAIT);
               else if (m_age == LOCK_STABLE_CYC + 1) enter(P_CORE);
            end
            P_CORE: begin
               if (!ls) begin failed = 1'b1; lost = 1'b1; end
               else if (m_age == RST_STAGE_GAP) enter(P_ADS);
            end
            P_ADS: begin
               if (!ls) begin failed = 1'b1; lost = 1'b1; end
               else if (m_age == RST_STAGE_GAP) begin enter(P_RUN); m_retry = 0; end
            end
            P_RUN:    if (!ls) begin failed = 1'b1; lost = 1'b1; end
            default: ;
         endcase
         if (failed) begin
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
            enter((m_retry == MAX_RETRY) ? P_FAULT : P_MRST);
            if (lost && LOSS_LOG && m_loss < 255) m_loss++;
         end
      end
   endtask

   task automatic compare_outputs();
      check("mmcm_rst",  32'(mmcm_rst),  32'(m_phase == P_MRST || m_phase == P_FAULT));
      check("clk_en",    32'(clk_en),    32'(m_phase == P_CORE || m_phase == P_ADS || m_phase == P_RUN));
      check("rst_core",  32'(rst_core),  32'(!(m_phase == P_ADS || m_phase == P_RUN)));
      check("rst_ads",   32'(rst_ads),   32'(m_phase != P_RUN));
      check("ready",     32'(ready),     32'(m_phase == P_RUN));
      check("fault",     32'(fault),     32'(m_phase == P_FAULT));
      check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
      check("loss_cnt",  32'(loss_cnt),  32'(m_loss));
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_step();
      cyc++;
      @(negedge sys_clk);
      compare_outputs();
   endtask

   task automatic pulse_soft(input logic lk);
      soft_rst = 1'b1;
      locked   = lk;
      tick();
      soft_rst = 1'b0;
      check("soft_fault",    32'(fault),     32'd0);
      check("soft_retry",    32'(retry_cnt), 32'd0);
      check("soft_mmcm_rst", 32'(mmcm_rst),  32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mmcm_rst"},  32'(mmcm_rst),  32'd1);
      check({tag, "_clk_en"},    32'(clk_en),    32'd0);
      check({tag, "_rst_core"},  32'(rst_core),  32'd1);
      check({tag, "_rst_ads"},   32'(rst_ads),   32'd1);
      check({tag, "_ready"},     32'(ready),     32'd0);
      check({tag, "_fault"},     32'(fault),     32'd0);
      check({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
      check({tag, "_loss_cnt"},  32'(loss_cnt),  32'd0);
   endtask

   initial begin
      int first_mr_low, first_ce, first_core, first_ads, first_rdy, first_fault, mr_falls, hold;
      logic prev_mr;

      sys_rst_n = 1'b0;
      locked    = 1'b0;
      soft_rst  = 1'b0;
      model_reset();
      repeat (3) tick();
      check_reset_values("por");

      // Clean bring-up: locked raised so that edge 10 is the first to sample it.
      sys_rst_n    = 1'b1;
      cyc          = 0;
      first_mr_low = -1; first_ce = -1; first_core = -1; first_ads = -1; first_rdy = -1;
      for (int t = 1; t <= 35; t++) begin
         if (t == 10) locked = 1'b1;
         tick();
         if (first_mr_low < 0 && !mmcm_rst) first_mr_low = t;
         if (first_ce   < 0 && clk_en)      first_ce     = t;
         if (first_core < 0 && !rst_core)   first_core   = t;
         if (first_ads  < 0 && !rst_ads)    first_ads    = t;
         if (first_rdy  < 0 && ready)       first_rdy    = t;
      end
      check("bringup_mmcm_rst_fall", first_mr_low, 4);
      check("bringup_clk_en_rise",   first_ce,     21);
      check("bringup_rst_core_fall", first_core,   25);
      check("bringup_rst_ads_fall",  first_ads,    29);
      check("bringup_ready_rise",    first_rdy,    29);
      check("bringup_retry",         32'(retry_cnt), 32'd0);

      // Loss in RUN: reaction on the third edge after locked falls.
      locked = 1'b0;
      tick();
      tick();
      check("loss_ready_held", 32'(ready), 32'd1);
      tick();
      check("loss_ready",    32'(ready),     32'd0);
      check("loss_clk_en",   32'(clk_en),    32'd0);
      check("loss_rst_core", 32'(rst_core),  32'd1);
      check("loss_rst_ads",  32'(rst_ads),   32'd1);
      check("loss_mmcm_rst", 32'(mmcm_rst),  32'd1);
      check("loss_retry",    32'(retry_cnt), 32'd1);
      check("loss_loss_cnt", 32'(loss_cnt),  LOSS_LOG ? 32'd1 : 32'd0);
      locked = 1'b1;
      repeat (40) tick();
      check("recover_ready", 32'(ready),     32'd1);
      check("recover_retry", 32'(retry_cnt), 32'd0);

      // Timeout to FAULT: two MRST pulses, each followed by a full WAIT_LOCK timeout.
      pulse_soft(1'b0);
      first_fault = -1;
      mr_falls    = 0;
      prev_mr     = mmcm_rst;
      for (int r = 1; r <= 130; r++) begin
         tick();
         if (prev_mr && !mmcm_rst) mr_falls++;
         prev_mr = mmcm_rst;
         if (first_fault < 0 && fault) first_fault = r;
      end
      check("timeout_fault_cycle", first_fault, 108);
      check("timeout_mmcm_pulses", mr_falls, 2);
      check("timeout_fault",       32'(fault),     32'd1);
      check("timeout_mmcm_rst",    32'(mmcm_rst),  32'd1);
      check("timeout_retry",       32'(retry_cnt), 32'd2);

      // soft_rst out of FAULT with lock present completes the sequence.
      pulse_soft(1'b1);
      first_rdy = -1;
      for (int r = 1; r <= 30; r++) begin
         tick();
         if (first_rdy < 0 && ready) first_rdy = r;
      end
      check("fault_restart_ready", first_rdy, 22);

      // One-cycle lock glitch after 5 stable cycles restarts the stable count.
      pulse_soft(1'b0);
      repeat (6) tick();
      locked = 1'b1;
      tick();
      first_ce  = -1;
      first_rdy = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 6) locked = 1'b0;
         if (k == 7) locked = 1'b1;
         tick();
         if (first_ce  < 0 && clk_en) first_ce  = k;
         if (first_rdy < 0 && ready)  first_rdy = k;
      end
      check("glitch_clk_en_rise", first_ce,  18);
      check("glitch_ready_rise",  first_rdy, 26);
      check("glitch_retry",       32'(retry_cnt), 32'd0);

      // Random lock traffic with occasional restart requests.
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            locked = ($urandom_range(0, 3) != 0);
            hold   = $urandom_range(1, 40);
         end
         hold--;
         soft_rst = ($urandom_range(0, 63) == 0);
         tick();
      end
      soft_rst = 1'b0;

      // Async reset in the middle of REL_ADS.
      pulse_soft(1'b1);
      repeat (19) tick();
      check("pre_arst_rst_core", 32'(rst_core), 32'd0);
      check("pre_arst_rst_ads",  32'(rst_ads),  32'd1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check_reset_values("arst");
      model_reset();
      repeat (2) tick();
      sys_rst_n = 1'b1;
      repeat (30) tick();
      check("post_arst_ready", 32'(ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
